display_scan: RTL and testbench

Upstream driver for the four-digit seven-segment display. It accepts a 14-bit binary value through a valid/ready handshake and converts it to four BCD digits with an iterative shift-add-3 sequencer. It then time-multiplexes those digits onto a single 4-bit digit bus and an active-low digit-enable vector. The digit bus feeds the team's seven-segment decoder directly, and that decoder blanks any code ≥ 10.

---
 rtl/display_pkg.sv | 29 ++
 rtl/display_scan_if.sv | 31 +++
 rtl/bin2bcd_iter.sv | 94 +++++++++
 rtl/display_scan.sv | 95 +++++++++
 tb/tb_display_scan.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// display_pkg
// Shared definitions for the four-digit seven-segment scan driver:
// digit count, saturation limit, blank code, converter state encoding,
// the BCD digit type and the per-step shift-add-3 helper.
package display_pkg;

    localparam int          NUM_DIGITS = 4;
    localparam logic [13:0] BCD_MAX    = 14'd9999;
    localparam logic [3:0]  BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_t;

    typedef logic [3:0] bcd_t;

    // One double-dabble step on the 30-bit register {bcd3..bcd0, bin[13:0]}:
    // every BCD nibble that is >= 5 gets +3, then the whole register moves
    // left by one bit.
    function automatic logic [29:0] add3_shift(input logic [29:0] sr);
        logic [29:0] t;
        t = sr;
        for (int n = 0; n < NUM_DIGITS; n++) begin
            if (t[14 + 4*n +: 4] >= 4'd5) begin
                t[14 + 4*n +: 4] = t[14 + 4*n +: 4] + 4'd3;
            end
        end
        return {t[28:0], 1'b0};
    endfunction

endpackage

// File: rtl/display_scan_if.sv
// display_scan_if
// Bundles the value handshake and the display outputs of display_scan.
//   value_i/valid_i : binary value offered by the producer
//   ready_o         : converter idle; a transfer happens when valid_i && ready_o
//                     are both high on a rising clock edge
//   ovf_o           : last accepted value was saturated to 9999
//   digit_o/an_o    : scanned BCD digit and active-low one-hot digit enable
//   conv_state      : converter FSM state, for observation only
// master = producer/observer side, slave = display_scan.
interface display_scan_if;
    import display_pkg::*;

    logic [13:0] value_i;
    logic        valid_i;
    logic        ready_o;
    logic        ovf_o;
    bcd_t        digit_o;
    logic [3:0]  an_o;
    conv_state_t conv_state;

    modport master (
        output value_i, valid_i,
        input  ready_o, ovf_o, digit_o, an_o, conv_state
    );

    modport slave (
        input  value_i, valid_i,
        output ready_o, ovf_o, digit_o, an_o, conv_state
    );

endinterface

// File: rtl/bin2bcd_iter.sv
// bin2bcd_iter
// Iterative 14-bit binary to 4-digit BCD converter (shift-add-3).
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   value_i      : binary input, saturated to 9999 on acceptance
//   valid_i      : value offered; accepted when ready_o is high
//   ready_o      : FSM in IDLE
//   ovf_o        : last accepted value exceeded 9999
//   done_o       : one-cycle pulse while bcd_o holds a finished result
//   bcd_o        : four BCD digits, index 0 least significant
//   state_o      : current FSM state
// Timing: transfer edge 0, shifts on edges 1..14, COMMIT state during the
// cycle that ends with edge 15, back in IDLE after edge 15.
module bin2bcd_iter
    import display_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] value_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        ovf_o,
    output logic        done_o,
    output bcd_t        bcd_o [NUM_DIGITS],
    output conv_state_t state_o
);

    conv_state_t state, state_n;
    logic [29:0] sr, sr_n;
    logic [3:0]  cnt, cnt_n;
    logic        ovf, ovf_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            sr    <= sr_n;
            cnt   <= cnt_n;
            ovf   <= ovf_n;
        end
    end

    always_comb begin
        state_n = state;
        sr_n    = sr;
        cnt_n   = cnt;
        ovf_n   = ovf;
        ready_o = 1'b0;
        done_o  = 1'b0;
        case (state)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    if (value_i > BCD_MAX) begin
                        sr_n  = {16'b0, BCD_MAX};
                        ovf_n = 1'b1;
                    end else begin
                        sr_n  = {16'b0, value_i};
                        ovf_n = 1'b0;
                    end
                    cnt_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                sr_n  = add3_shift(sr);
                cnt_n = cnt + 4'd1;
                // cnt still reads 13 while the 14th shift is being taken
                if (cnt == 4'd13) begin
                    state_n = COMMIT;
                end
            end
            COMMIT: begin
                done_o  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            bcd_o[i] = sr[14 + 4*i +: 4];
        end
    end

    assign ovf_o   = ovf;
    assign state_o = state;

endmodule

// File: rtl/display_scan.sv
// display_scan
// Accepts a binary value, converts it to BCD through bin2bcd_iter and
// time-multiplexes the four digits onto digit_o / an_o.
// Ports:
//   clk    : clock, all state changes on the rising edge
//   rst_n  : synchronous active-low reset
//   bus    : display_scan_if.slave (value/valid/ready handshake, ovf flag,
//            scanned digit, active-low digit enables, converter state)
// Parameter SCAN_DIV (>= 2): cycles each digit stays enabled.
// Optional macro DISPLAY_SCAN_BLANK_EN: leading zeros above the highest
// non-zero digit are stored as BLANK_CODE at commit; digit 0 always shows.
module display_scan
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    display_scan_if.slave bus
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] pre;
    logic [1:0]    idx;
    bcd_t          digits     [NUM_DIGITS];
    bcd_t          conv_bcd   [NUM_DIGITS];
    bcd_t          commit_bcd [NUM_DIGITS];
    logic          done;

    bin2bcd_iter u_conv (
        .clk     (clk),
        .rst_n   (rst_n),
        .value_i (bus.value_i),
        .valid_i (bus.valid_i),
        .ready_o (bus.ready_o),
        .ovf_o   (bus.ovf_o),
        .done_o  (done),
        .bcd_o   (conv_bcd),
        .state_o (bus.conv_state)
    );

    always_comb begin
`ifdef DISPLAY_SCAN_BLANK_EN
        logic lead;
        lead = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            commit_bcd[i] = conv_bcd[i];
        end
        // Walk from the most significant digit down; stop blanking at the
        // first non-zero digit. Digit 0 is never considered.
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (lead && (conv_bcd[i] == 4'd0)) begin
                commit_bcd[i] = BLANK_CODE;
            end else begin
                lead = 1'b0;
            end
        end
`else
        for (int i = 0; i < NUM_DIGITS; i++) begin
            commit_bcd[i] = conv_bcd[i];
        end
`endif
    end

    // The whole digit register is written in one edge, so the scan never
    // sees a partially converted value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digits[i] <= '0;
            end
        end else if (done) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digits[i] <= commit_bcd[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre <= '0;
            idx <= '0;
        end else if (pre == PW'(SCAN_DIV - 1)) begin
            pre <= '0;
            idx <= idx + 2'd1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    assign bus.an_o    = ~(4'b0001 << idx);
    assign bus.digit_o = digits[idx];

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan
// Directed bench for display_scan with SCAN_DIV = 4.
module tb_display_scan;
    import display_pkg::*;

    localparam int SD = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    display_scan_if bus ();

    display_scan #(.SCAN_DIV(SD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scan reference ----------------
    int m_pre;
    int m_idx;
    always @(posedge clk) begin
        if (!rst_n) begin
            m_pre <= 0;
            m_idx <= 0;
        end else if (m_pre == SD - 1) begin
            m_pre <= 0;
            m_idx <= (m_idx + 1) % 4;
        end else begin
            m_pre <= m_pre + 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected 4-nibble display word (nibble i = digit i) for a raw input.
    function automatic logic [15:0] exp_disp(input int v);
        int s;
        logic [15:0] w;
        s = (v > 9999) ? 9999 : v;
        w[3:0]   = 4'(s % 10);
        w[7:4]   = 4'((s / 10) % 10);
        w[11:8]  = 4'((s / 100) % 10);
        w[15:12] = 4'((s / 1000) % 10);
`ifdef DISPLAY_SCAN_BLANK_EN
        if (s < 1000) w[15:12] = 4'hF;
        if (s < 100)  w[11:8]  = 4'hF;
        if (s < 10)   w[7:4]   = 4'hF;
`endif
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.ready_o !== 1'b1 && n < 40) begin
            n++;
            step();
        end
        check("wait_ready_timeout", {31'b0, bus.ready_o}, 32'd1);
    endtask

    // Offer v, check the overflow flag right after the transfer edge and
    // measure how many sampled cycles ready_o stays low.
    task automatic send(input int v, input logic exp_ovf);
        int n;
        wait_ready();
        bus.value_i = 14'(v);
        bus.valid_i = 1'b1;
        step();
        bus.valid_i = 1'b0;
        check("ovf_after_transfer", {31'b0, bus.ovf_o}, {31'b0, exp_ovf});
        n = 0;
        while (bus.ready_o !== 1'b1 && n < 40) begin
            n++;
            step();
        end
        check("busy_cycles", n, 15);
    endtask

    // Watch one full refresh plus change, comparing against the reference index.
    task automatic check_scan(input string tag, input logic [15:0] exp);
        logic [3:0] an_exp;
        logic [3:0] d_exp;
        for (int c = 0; c < 4 * SD + 2; c++) begin
            an_exp = ~(4'b0001 << m_idx);
            d_exp  = exp[m_idx*4 +: 4];
            check({tag, "_an"}, {28'b0, bus.an_o}, {28'b0, an_exp});
            check({tag, "_digit"}, {28'b0, bus.digit_o}, {28'b0, d_exp});
            step();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] w;
        logic [3:0]  d_exp;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.valid_i = 1'b0;
        bus.value_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset values and free-running scan
        check("rst_an", {28'b0, bus.an_o}, 32'hE);
        check("rst_digit", {28'b0, bus.digit_o}, 32'h0);
        check("rst_ready", {31'b0, bus.ready_o}, 32'd1);
        check("rst_ovf", {31'b0, bus.ovf_o}, 32'd0);
        check("rst_state", {30'b0, bus.conv_state}, {30'b0, IDLE});
        check_scan("rst_scan", 16'h0000);

        // basic conversion
        send(1234, 1'b0);
        check_scan("v1234", 16'h1234);

        // saturation, then clearing the flag
        send(12000, 1'b1);
        check("ovf_hold", {31'b0, bus.ovf_o}, 32'd1);
        check_scan("v12000", exp_disp(12000));
        send(5, 1'b0);
        check_scan("v5", exp_disp(5));

        // boundaries of saturation
        send(9999, 1'b0);
        check_scan("v9999", 16'h9999);
        send(10000, 1'b1);
        check_scan("v10000", 16'h9999);

        // valid held high with changing values during a conversion
        wait_ready();
        w = exp_disp(2468);
        for (int k = 0; k <= 16; k++) begin
            if (k == 0) bus.value_i = 14'd2468;
            else if (k % 2 == 0) bus.value_i = 14'd1357;
            else bus.value_i = 14'd8642;
            bus.valid_i = 1'b1;
            step();
            if (k < 15) begin
                check("held_busy", {31'b0, bus.ready_o}, 32'd0);
            end else if (k == 15) begin
                check("held_ready_e15", {31'b0, bus.ready_o}, 32'd1);
                d_exp = w[m_idx*4 +: 4];
                check("held_first_digit", {28'b0, bus.digit_o}, {28'b0, d_exp});
            end
        end
        bus.valid_i = 1'b0;
        check("held_second_accepted", {31'b0, bus.ready_o}, 32'd0);
        wait_ready();
        check_scan("held_1357", exp_disp(1357));

        // reset in the middle of a conversion
        send(1111, 1'b0);
        check_scan("v1111", 16'h1111);
        bus.value_i = 14'd4321;
        bus.valid_i = 1'b1;
        step();
        bus.valid_i = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_ready", {31'b0, bus.ready_o}, 32'd1);
        check("mid_rst_ovf", {31'b0, bus.ovf_o}, 32'd0);
        check("mid_rst_an", {28'b0, bus.an_o}, 32'hE);
        check("mid_rst_digit", {28'b0, bus.digit_o}, 32'h0);
        check("mid_rst_state", {30'b0, bus.conv_state}, {30'b0, IDLE});
        repeat (20) step();
        check_scan("mid_rst_scan", 16'h0000);

        // zero value
        send(0, 1'b0);
        check_scan("v0", exp_disp(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
